// File: rtl/mult_ctl_pkg.sv
// Shared types and helpers for the radix-2^DIGIT multiplier control.
// Imported by the control top, its digit scanner and the bus interface.
package mult_ctl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_CHECK,
    S_ADD,
    S_SHIFT,
    S_DONE
  } state_e;

  function automatic int cw_of(int w, int d);
    return $clog2(w / d + 1);
  endfunction

  function automatic bit digit_ok(int w, int d);
    return (w % d) == 0;
  endfunction

endpackage

// File: rtl/mult_control_radix_taint_if.sv
// Start/done handshake plus datapath strobes of the multiplier control.
// The slave modport is the control unit; master is the system side.
interface mult_control_radix_taint_if
  import mult_ctl_pkg::*;
#(
  parameter int WIDTH = 2048,
  parameter int DIGIT = 1,
  parameter int CW    = cw_of(WIDTH, DIGIT)
);
  logic             start;
  logic             start_t;
  logic             taint_clr;
  logic [WIDTH-1:0] multiplierReg;
  logic [WIDTH-1:0] multiplierReg_t;
  logic             busy;
  logic             busy_t;
  logic             done;
  logic             done_t;
  logic             mdld;
  logic             mdld_t;
  logic             mrld;
  logic             mrld_t;
  logic             rsclear;
  logic             rsclear_t;
  logic             rsload;
  logic             rsload_t;
  logic [DIGIT-1:0] digit_sel;
  logic [DIGIT-1:0] digit_sel_t;
  logic             rsshr;
  logic             rsshr_t;
  logic [CW-1:0]    shamt;
  logic [CW-1:0]    shamt_t;

  modport master (
    output start, start_t, taint_clr,
    output multiplierReg, multiplierReg_t,
    input  busy, busy_t, done, done_t,
    input  mdld, mdld_t, mrld, mrld_t,
    input  rsclear, rsclear_t,
    input  rsload, rsload_t,
    input  digit_sel, digit_sel_t,
    input  rsshr, rsshr_t, shamt, shamt_t
  );

  modport slave (
    input  start, start_t, taint_clr,
    input  multiplierReg, multiplierReg_t,
    output busy, busy_t, done, done_t,
    output mdld, mdld_t, mrld, mrld_t,
    output rsclear, rsclear_t,
    output rsload, rsload_t,
    output digit_sel, digit_sel_t,
    output rsshr, rsshr_t, shamt, shamt_t
  );

endinterface

// File: rtl/mult_digit_scan.sv
// Combinational view of the multiplier digits around the counter:
// current/next digit, their taints, and the all-zero / taint of the rest.
module mult_digit_scan
  import mult_ctl_pkg::*;
#(
  parameter int WIDTH = 2048,
  parameter int DIGIT = 1,
  parameter int CW    = cw_of(WIDTH, DIGIT)
) (
  input  logic [WIDTH-1:0] mr,
  input  logic [WIDTH-1:0] mr_t,
  input  logic [CW-1:0]    cnt,
  output logic [DIGIT-1:0] cur,
  output logic [DIGIT-1:0] cur_t,
  output logic [DIGIT-1:0] nxt,
  output logic [DIGIT-1:0] nxt_t,
  output logic             upper_zero,
  output logic             upper_t
);
  localparam int ND = WIDTH / DIGIT;

  logic [CW-1:0] cnt_n;
  assign cnt_n = cnt + CW'(1);

  // cnt+1 may equal ND; that slot matches no digit and reads as zero
  always_comb begin
    cur        = '0;
    cur_t      = '0;
    nxt        = '0;
    nxt_t      = '0;
    upper_zero = 1'b1;
    upper_t    = 1'b0;
    for (int i = 0; i < ND; i++) begin
      if (CW'(i) == cnt) begin
        cur   = mr[i*DIGIT +: DIGIT];
        cur_t = mr_t[i*DIGIT +: DIGIT];
      end
      if (CW'(i) == cnt_n) begin
        nxt   = mr[i*DIGIT +: DIGIT];
        nxt_t = mr_t[i*DIGIT +: DIGIT];
      end
      if (CW'(i) > cnt) begin
        upper_zero = upper_zero & ~(|mr[i*DIGIT +: DIGIT]);
        upper_t    = upper_t | (|mr_t[i*DIGIT +: DIGIT]);
      end
    end
  end

endmodule

// File: rtl/mult_control_radix_taint.sv
// Radix-2^DIGIT shift-add multiplier control with zero-digit skip,
// optional early exit and a sticky control-taint bit on every output.
module mult_control_radix_taint
  import mult_ctl_pkg::*;
#(
  parameter int WIDTH      = 2048,
  parameter int DIGIT      = 1,
  parameter bit EARLY_EXIT = 1'b1
) (
  input logic clk,
  input logic rst,
  mult_control_radix_taint_if.slave bus
);
  localparam int ND = WIDTH / DIGIT;
  localparam int CW = cw_of(WIDTH, DIGIT);

  if (!digit_ok(WIDTH, DIGIT)) begin : g_bad_digit
    $error("WIDTH must be a multiple of DIGIT");
  end

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ctl_q, ctl_d;
  logic          upd;
  logic          last;

  logic [DIGIT-1:0] cur, cur_t, nxt, nxt_t;
  logic             upper_zero, upper_t;

  mult_digit_scan #(
    .WIDTH (WIDTH),
    .DIGIT (DIGIT),
    .CW    (CW)
  ) u_scan (
    .mr         (bus.multiplierReg),
    .mr_t       (bus.multiplierReg_t),
    .cnt        (cnt_q),
    .cur        (cur),
    .cur_t      (cur_t),
    .nxt        (nxt),
    .nxt_t      (nxt_t),
    .upper_zero (upper_zero),
    .upper_t    (upper_t)
  );

  assign last = (cnt_q == CW'(ND - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ctl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctl_q   <= ctl_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ctl_d         = ctl_q;
    upd           = 1'b0;
    bus.busy      = (state_q != S_IDLE);
    bus.done      = 1'b0;
    bus.mdld      = 1'b0;
    bus.mrld      = 1'b0;
    bus.rsclear   = 1'b0;
    bus.rsload    = 1'b0;
    bus.digit_sel = '0;
    bus.rsshr     = 1'b0;
    bus.shamt     = '0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_INIT;
          cnt_d   = '0;
        end
        if (bus.start_t)        ctl_d = 1'b1;
        else if (bus.taint_clr) ctl_d = 1'b0;
      end
      S_INIT: begin
        bus.mdld    = 1'b1;
        bus.mrld    = 1'b1;
        bus.rsclear = 1'b1;
        state_d     = S_CHECK;
      end
      S_CHECK: begin
        upd     = |cur_t;
        state_d = (|cur) ? S_ADD : S_SHIFT;
      end
      S_ADD: begin
        bus.rsload    = 1'b1;
        bus.digit_sel = cur;
        state_d       = S_SHIFT;
      end
      S_SHIFT: begin
        bus.rsshr = 1'b1;
        upd       = EARLY_EXIT ? upper_t : |nxt_t;
        if (last) begin
          bus.shamt = CW'(1);
          state_d   = S_DONE;
        end else if (EARLY_EXIT && upper_zero) begin
          // collapse every remaining zero digit into one shift
          bus.shamt = CW'(ND) - cnt_q;
          state_d   = S_DONE;
        end else begin
          bus.shamt = CW'(1);
          cnt_d     = cnt_q + CW'(1);
          state_d   = (|nxt) ? S_ADD : S_SHIFT;
        end
      end
      S_DONE: begin
        bus.done = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    ctl_d = ctl_d | upd;
  end

  assign bus.busy_t    = ctl_q;
  assign bus.done_t    = ctl_q;
  assign bus.mdld_t    = ctl_q;
  assign bus.mrld_t    = ctl_q;
  assign bus.rsclear_t = ctl_q;
  assign bus.rsload_t  = ctl_q;
  assign bus.rsshr_t   = ctl_q;
  assign bus.shamt_t   = {CW{ctl_q | upd}};
  assign bus.digit_sel_t =
    ((state_q == S_ADD) ? cur_t : '0) | {DIGIT{ctl_q}};

endmodule
